// File: rtl/stopwatch_ctrl_pkg.sv
// Shared state encoding and default sizing for the stopwatch sequencer.
package stopwatch_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    ALARM = 2'd3
  } state_t;

  localparam int DEF_PRESCALE = 10;
  localparam int DEF_WIDTH    = 16;

endpackage

// File: rtl/stopwatch_ctrl_tick_gen.sv
// Prescaler: advances on enabled cycles and flags the cycle it wraps from PRESCALE-1.
// Holding enable low freezes the phase so pause/resume loses no partial period.
module tick_gen #(
  parameter int PRESCALE = 10
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int PW = $clog2(PRESCALE);
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] phase;

  assign tick = enable && (phase == LAST);

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      phase <= '0;
    end else if (enable) begin
      phase <= (phase == LAST) ? '0 : phase + PW'(1);
    end
  end

endmodule

// File: rtl/up_counter.sv
// Enable / synchronous-clear up counter paced by the stopwatch sequencer.
module up_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             sync_rst,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clock) begin
    if (reset || sync_rst) begin
      count <= '0;
    end else if (enable) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: button edges drive IDLE/RUN/PAUSE/ALARM and pace the external counter.
// All outputs are registered; actions take effect the cycle after the button edge.
module stopwatch_ctrl
  import stopwatch_ctrl_pkg::*;
#(
  parameter int PRESCALE = DEF_PRESCALE,
  parameter int WIDTH    = DEF_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start_stop,
  input  logic             clear,
  input  logic             lap,
  input  logic [WIDTH-1:0] target,
  input  logic [WIDTH-1:0] count,
  output logic             cnt_en,
  output logic             cnt_rst,
  output logic [WIDTH-1:0] lap_value,
  output logic             lap_valid,
  output logic             running,
  output logic             alarm
);

  state_t state, state_nxt;
  logic   ss_prev, clr_prev, lap_prev;
  logic   ss_edge, clr_edge, lap_edge;
  logic   alarm_hit, do_ss, do_lap, tick;

  assign ss_edge  = start_stop & ~ss_prev;
  assign clr_edge = clear & ~clr_prev;
  assign lap_edge = lap & ~lap_prev;

  // Clear outranks everything; an alarm match outranks start_stop and lap.
  always_comb begin
    alarm_hit = (state == RUN) && (target != '0) && (count == target) && !clr_edge;
    do_ss     = ss_edge && !clr_edge && !alarm_hit;
    do_lap    = lap_edge && !clr_edge && !ss_edge && !alarm_hit &&
                ((state == RUN) || (state == PAUSE));
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (clr_edge) state_nxt = IDLE;
             else if (do_ss) state_nxt = RUN;
      RUN:   if (clr_edge) state_nxt = RUN;
             else if (alarm_hit) state_nxt = ALARM;
             else if (do_ss) state_nxt = PAUSE;
      PAUSE: if (clr_edge) state_nxt = IDLE;
             else if (do_ss) state_nxt = RUN;
      ALARM: if (clr_edge) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  tick_gen #(.PRESCALE(PRESCALE)) u_tick_gen (
    .clock  (clock),
    .reset  (reset),
    .enable ((state == RUN) && !alarm_hit),
    .clear  (clr_edge),
    .tick   (tick)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      ss_prev   <= 1'b0;
      clr_prev  <= 1'b0;
      lap_prev  <= 1'b0;
      cnt_en    <= 1'b0;
      cnt_rst   <= 1'b0;
      lap_value <= '0;
      lap_valid <= 1'b0;
      running   <= 1'b0;
      alarm     <= 1'b0;
    end else begin
      state     <= state_nxt;
      ss_prev   <= start_stop;
      clr_prev  <= clear;
      lap_prev  <= lap;
      cnt_en    <= tick && !clr_edge;
      cnt_rst   <= clr_edge;
      lap_valid <= do_lap;
      if (do_lap) begin
        lap_value <= count;
      end
      running   <= (state_nxt == RUN);
      alarm     <= (state_nxt == ALARM);
    end
  end

endmodule
